// File: rtl/loopyv_mem_arbiter.sv
// loopyv_mem_arbiter: shares one memory port between fetch and data requesters, data-first with fetch anti-starvation
// Ports: clk, rstN (async active-low);
//   fetch:  ifReq, ifAddr -> ifGnt, ifRvalid, ifRdata
//   data:   dmReq, dmWe, dmBe, dmAddr, dmWdata -> dmGnt, dmRvalid, dmRdata
//   bus:    busReq, busWe, busBe, busAddr, busWdata <- busGnt, busRvalid, busRdata
//   protoErr: sticky flag raised by a bus response arriving with nothing outstanding
module loopyv_mem_arbiter #(
  parameter int IF_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic        ifGnt,
  output logic        ifRvalid,
  output logic [31:0] ifRdata,
  input  logic        dmReq,
  input  logic        dmWe,
  input  logic [3:0]  dmBe,
  input  logic [31:0] dmAddr,
  input  logic [31:0] dmWdata,
  output logic        dmGnt,
  output logic        dmRvalid,
  output logic [31:0] dmRdata,
  output logic        busReq,
  output logic        busWe,
  output logic [3:0]  busBe,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  input  logic        busGnt,
  input  logic        busRvalid,
  input  logic [31:0] busRdata,
  output logic        protoErr
);
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e;
  localparam logic [2:0] STARVE_MAX = 3'(IF_STARVE_MAX);
  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic [2:0] starve_q, starve_d;
  logic perr_q, perr_d;
  logic dm_win, sel_if, sel_dm, bus_req, gnt, rv;
  assign dm_win = dmReq && !(ifReq && starve_q == STARVE_MAX);
  // IDLE picks the winner combinationally; afterwards the registered owner keeps the bus
  assign sel_dm = state_q == IDLE ? dm_win : owner_q == OWN_DM;
  assign sel_if = state_q == IDLE ? ifReq && !dm_win : owner_q == OWN_IF;
  // rstN gates the combinational request path so nothing escapes while reset is held
  assign bus_req = rstN && state_q != RESP && (sel_if || sel_dm);
  assign gnt = bus_req && busGnt;
  assign rv = rstN && state_q == RESP && busRvalid;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      perr_q   <= perr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: if (bus_req) begin
        state_d = busGnt ? RESP : ADDR;
        owner_d = sel_dm ? OWN_DM : OWN_IF;
      end
      ADDR: if (busGnt) state_d = RESP;
      RESP: if (busRvalid) begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
    // a data grant only counts toward starvation while a fetch is actually waiting
    starve_d = !gnt ? starve_q :
               (sel_if || !ifReq) ? 3'd0 :
               starve_q >= STARVE_MAX ? STARVE_MAX : starve_q + 3'd1;
    // a response outside RESP (including one coinciding with a grant in ADDR) is spurious
    perr_d = perr_q || (busRvalid && state_q != RESP);
  end
  always_comb begin
    busReq   = bus_req;
    busWe    = bus_req && sel_dm && dmWe;
    busBe    = !bus_req ? 4'h0 : sel_dm ? dmBe : 4'hF;
    busAddr  = !bus_req ? 32'd0 : sel_dm ? dmAddr : ifAddr;
    busWdata = bus_req && sel_dm ? dmWdata : 32'd0;
    ifGnt    = gnt && sel_if;
    dmGnt    = gnt && sel_dm;
    ifRvalid = rv && owner_q == OWN_IF;
    dmRvalid = rv && owner_q == OWN_DM;
    ifRdata  = ifRvalid ? busRdata : 32'd0;
    dmRdata  = dmRvalid ? busRdata : 32'd0;
    protoErr = perr_q;
  end
endmodule

// File: tb/tb_loopyv_mem_arbiter.sv
// tb_loopyv_mem_arbiter: scoreboard bench with a transaction-level arbiter model and a randomized memory responder
module tb_loopyv_mem_arbiter;
  localparam int SMAX = 4;
  logic clk = 1'b0, rstN = 1'b0;
  logic ifReq = 1'b0;
  logic [31:0] ifAddr = '0;
  logic dmReq = 1'b0, dmWe = 1'b0;
  logic [3:0] dmBe = '0;
  logic [31:0] dmAddr = '0, dmWdata = '0;
  logic busGnt = 1'b0, busRvalid = 1'b0;
  logic [31:0] busRdata = '0;
  logic ifGnt, ifRvalid, dmGnt, dmRvalid, busReq, busWe, protoErr;
  logic [31:0] ifRdata, dmRdata, busAddr, busWdata;
  logic [3:0] busBe;
  loopyv_mem_arbiter #(.IF_STARVE_MAX(SMAX)) dut (
    .clk(clk), .rstN(rstN),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifRvalid(ifRvalid), .ifRdata(ifRdata),
    .dmReq(dmReq), .dmWe(dmWe), .dmBe(dmBe), .dmAddr(dmAddr), .dmWdata(dmWdata),
    .dmGnt(dmGnt), .dmRvalid(dmRvalid), .dmRdata(dmRdata),
    .busReq(busReq), .busWe(busWe), .busBe(busBe), .busAddr(busAddr), .busWdata(busWdata),
    .busGnt(busGnt), .busRvalid(busRvalid), .busRdata(busRdata), .protoErr(protoErr)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic rst; logic req; logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;
    logic chk_attr; logic ignt; logic dgnt; logic rv; logic perr;
  } exp_t;
  typedef struct packed {logic own_dm; logic [31:0] data;} rsp_t;
  exp_t exp_q[$];
  rsp_t rsp_q[$];
  int gnt_pct = 100, rv_lo = 0, rv_hi = 0;
  logic inject = 1'b0, rd_rand = 1'b0, done = 1'b0;
  logic [31:0] rd_val = 32'h13;
  logic g_if, g_dm;
  // reference model: one transaction at a time, phase 0 free / 1 address / 2 awaiting data
  int m_phase = 0, m_starve = 0;
  logic m_dm = 1'b0, m_perr = 1'b0;
  exp_t me;
  rsp_t mr;
  always @(negedge clk) begin
    me = '0;
    if (!rstN) begin
      m_phase = 0; m_starve = 0; m_perr = 1'b0;
      me.rst = 1'b1; me.chk_attr = 1'b1;
    end else begin
      if (m_phase == 0 && (ifReq || dmReq)) begin
        m_dm = dmReq && !(ifReq && m_starve == SMAX);
        m_phase = 1;
      end
      me.perr = m_perr;
      me.chk_attr = m_phase != 2;
      if (m_phase == 1) begin
        me.req = 1'b1;
        me.we = m_dm && dmWe;
        me.be = m_dm ? dmBe : 4'hF;
        me.addr = m_dm ? dmAddr : ifAddr;
        me.wdata = m_dm ? dmWdata : 32'd0;
        me.ignt = busGnt && !m_dm;
        me.dgnt = busGnt && m_dm;
      end
      if (m_phase == 2 && busRvalid) begin
        me.rv = 1'b1;
        mr.own_dm = m_dm; mr.data = busRdata;
        rsp_q.push_back(mr);
      end
      if (busRvalid && m_phase != 2) m_perr = 1'b1;
      if (m_phase == 1 && busGnt) begin
        m_starve = (m_dm && ifReq) ? (m_starve < SMAX ? m_starve + 1 : SMAX) : 0;
        m_phase = 2;
      end else if (m_phase == 2 && busRvalid) m_phase = 0;
    end
    exp_q.push_back(me);
  end
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
  endtask
  exp_t e;
  rsp_t r;
  always @(negedge clk) begin
    #1;
    e = exp_q.pop_front();
    chk("busReq", 32'(busReq), 32'(e.req));
    if (e.chk_attr) begin
      chk("busWe", 32'(busWe), 32'(e.we));
      chk("busBe", 32'(busBe), 32'(e.be));
      chk("busAddr", busAddr, e.addr);
      chk("busWdata", busWdata, e.wdata);
    end
    chk("ifGnt", 32'(ifGnt), 32'(e.ignt));
    chk("dmGnt", 32'(dmGnt), 32'(e.dgnt));
    chk("protoErr", 32'(protoErr), 32'(e.perr));
    chk("rvalid_any", 32'(ifRvalid || dmRvalid), 32'(e.rv));
    if (ifRvalid || dmRvalid) begin
      if (rsp_q.size() == 0) begin
        n_chk++;
        $display("FAIL rvalid_unexpected: if=%b dm=%b with no response due at %0t", ifRvalid, dmRvalid, $time);
      end else begin
        r = rsp_q.pop_front();
        chk("rvalid_owner_dm", 32'(dmRvalid), 32'(r.own_dm));
        chk("rvalid_other_if", 32'(ifRvalid), 32'(!r.own_dm));
        chk("rdata", dmRvalid ? dmRdata : ifRdata, r.data);
      end
    end else if (rsp_q.size() > 0) void'(rsp_q.pop_front());
    if (!ifRvalid) chk("ifRdata_idle", ifRdata, 32'd0);
    if (!dmRvalid) chk("dmRdata_idle", dmRdata, 32'd0);
    if (done) begin
      chk("responses_drained", rsp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end
  // memory responder: random grant, response after a bounded delay, optional spurious pulse
  initial begin
    logic pend;
    int cnt;
    pend = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      if (!rstN) pend = 1'b0;
      else if (pend && busRvalid) pend = 1'b0;
      else if (!pend && busReq && busGnt) begin
        pend = 1'b1;
        cnt = $urandom_range(rv_hi, rv_lo);
      end
      @(posedge clk);
      #2;
      busGnt = 1'b0; busRvalid = inject; busRdata = '0;
      if (pend) begin
        if (cnt == 0) begin
          busRvalid = 1'b1;
          busRdata = rd_rand ? $urandom : rd_val;
        end else cnt--;
      end else busGnt = $urandom_range(99, 0) < gnt_pct;
    end
  end
  task automatic cyc();
    @(negedge clk);
    g_if = ifGnt; g_dm = dmGnt;
    @(posedge clk);
    #1;
  endtask
  task automatic step();
    cyc();
    if (g_if) ifReq = 1'b0;
    if (g_dm) dmReq = 1'b0;
  endtask
  initial begin
    int n;
    repeat (3) cyc();
    rstN = 1'b1;
    cyc();
    ifReq = 1'b1; ifAddr = 32'h100;
    repeat (4) step();
    rd_val = 32'hCAFE_0001;
    ifReq = 1'b1; ifAddr = 32'h104;
    dmReq = 1'b1; dmWe = 1'b1; dmBe = 4'b0011; dmAddr = 32'h2000; dmWdata = 32'hA5A5_1234;
    repeat (7) step();
    ifReq = 1'b1; ifAddr = 32'h200;
    dmReq = 1'b1; dmWe = 1'b0; dmBe = 4'hF; dmAddr = 32'h3000;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (g_if) ifReq = 1'b0;
      if (g_dm) begin
        n++;
        dmReq = n < 6;
        dmAddr = 32'h3000 + 32'(n * 4);
      end
    end
    gnt_pct = 0;
    dmReq = 1'b1; dmWe = 1'b1; dmBe = 4'b1100; dmAddr = 32'h4000; dmWdata = 32'h1111_2222;
    cyc();
    ifReq = 1'b1; ifAddr = 32'h300;
    cyc();
    cyc();
    gnt_pct = 100;
    repeat (6) step();
    rv_lo = 8; rv_hi = 8;
    dmReq = 1'b1; dmAddr = 32'h5000;
    step();
    step();
    step();
    rstN = 1'b0;
    cyc();
    rstN = 1'b1;
    cyc();
    inject = 1'b1;
    cyc();
    inject = 1'b0;
    repeat (3) cyc();
    rstN = 1'b0;
    cyc();
    rstN = 1'b1;
    gnt_pct = 60; rv_lo = 0; rv_hi = 3; rd_rand = 1'b1;
    repeat (3000) begin
      cyc();
      if (g_if || !ifReq) begin
        ifReq = 1'($urandom_range(1, 0));
        ifAddr = $urandom & 32'hFFFF_FFFC;
      end
      if (g_dm || !dmReq) begin
        dmReq = $urandom_range(3, 0) != 0;
        dmWe = 1'($urandom_range(1, 0));
        dmBe = 4'($urandom);
        dmAddr = $urandom;
        dmWdata = $urandom;
      end
    end
    for (int i = 0; i < 40; i++) step();
    done = 1'b1;
  end
endmodule

// File: doc/loopyv_mem_arbiter.md
LOOPYV_MEM_ARBITER -- requirements
Module: loopyv_mem_arbiter

Interface
REQ-001 SHALL have parameter IF_STARVE_MAX, default 4: maximum consecutive data grants while a fetch is pending.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rstN  in  1  asynchronous active-low reset.
REQ-005 SHALL have port ifReq  in  1  fetch request (read only).
REQ-006 SHALL have port ifAddr  in  32  fetch address.
REQ-007 SHALL have ports ifGnt out 1, ifRvalid out 1 and ifRdata out 32: fetch grant, response valid, and instruction word.
REQ-008 SHALL have ports dmReq in 1, dmWe in 1, dmBe in 4, dmAddr in 32 and dmWdata in 32: data request, write enable, byte enables, address, and write data.
REQ-009 SHALL have ports dmGnt out 1, dmRvalid out 1 and dmRdata out 32: data grant, response valid, and load data.
REQ-010 SHALL have ports busReq out 1, busWe out 1, busBe out 4, busAddr out 32 and busWdata out 32: shared memory port request and attributes.
REQ-011 SHALL have ports busGnt in 1, busRvalid in 1 and busRdata in 32: bus address accept, response valid (also the write acknowledge), and read data.
REQ-012 SHALL have port protoErr  out  1  sticky flag for a spurious bus response.

Function
REQ-013 SHALL implement FSM states IDLE, ADDR and RESP, with at most one bus transaction outstanding.
REQ-014 Requesters SHALL hold req and all attributes stable until the grant cycle, and a grant SHALL only ever be given while the matching req is high.
REQ-015 In IDLE with any req high, SHALL select a winner combinationally, drive busReq=1 with the winner's attributes in the same cycle, and register the owner.
REQ-016 Winner selection SHALL be: dmReq wins over ifReq, except when starveCnt==IF_STARVE_MAX and ifReq=1, in which case IF wins.
REQ-017 Fetch accesses SHALL drive busWe=0 and busBe=4'hF, and busWdata=0.
REQ-018 ifGnt/dmGnt SHALL equal busReq & busGnt for the current owner, asserted only in that cycle.
REQ-019 IDLE SHALL go to RESP if busGnt in the arbitration cycle, else to ADDR.
REQ-020 ADDR SHALL keep busReq=1 with the locked owner's attributes; no re-arbitration is allowed even if the other req rises; on busGnt go to RESP.
REQ-021 RESP SHALL drive busReq=0; on busRvalid, SHALL pulse the owner's Rvalid for 1 cycle with Rdata=busRdata, the other Rvalid SHALL stay 0, and the FSM SHALL go to IDLE.
REQ-022 Minimum access SHALL be 2 cycles (grant cycle, then response); a new arbitration SHALL occur at the earliest in the cycle after Rvalid.
REQ-023 starveCnt (3 bits, saturating at IF_STARVE_MAX) SHALL increment on a DM grant while ifReq=1, clear on an IF grant, and clear on a DM grant with ifReq=0.
REQ-024 ifRdata/dmRdata SHALL be 0 when the corresponding Rvalid is 0.
REQ-025 busRvalid in IDLE or ADDR SHALL be ignored (no Rvalid output) and SHALL set protoErr=1 until reset.
REQ-026 busRvalid and busGnt together in ADDR SHALL be treated as a grant only; the rvalid is spurious per REQ-025.

Reset
REQ-027 rstN=0 SHALL asynchronously force: state=IDLE, owner=none, starveCnt=0, protoErr=0.
REQ-028 During and immediately after reset, all outputs SHALL be 0.
REQ-029 Reset mid-transaction SHALL discard the outstanding response, and a later busRvalid in IDLE SHALL set protoErr.
REQ-030 The first arbitration SHALL occur in the first clk edge cycle with rstN=1.

Verification
REQ-031 Single fetch: ifReq=1 with ifAddr=0x100, busGnt=1 immediately, busRvalid one cycle later with busRdata=0x00000013 -> ifGnt in cycle 0, ifRvalid=1 with ifRdata=0x13 in cycle 1, dmRvalid=0.
REQ-032 Simultaneous requests: ifReq=dmReq=1 with dmWe=1, dmBe=4'b0011, dmAddr=0x2000 -> busWe=1, busBe=0011, busAddr=0x2000 first; IF is served after the dm Rvalid.
REQ-033 Starvation: dmReq held high for 6 back-to-back accesses with ifReq=1, IF_STARVE_MAX=4 -> the 5th grant goes to IF, then DM resumes.
REQ-034 Grant wait: busGnt held 0 for 3 cycles while dmReq is pending and ifReq rises -> busAddr stays at the DM address, no ifGnt, dmGnt on the 4th cycle.
REQ-035 Reset mid-operation: rstN pulsed low in RESP, then busRvalid=1 after release -> no Rvalid on either side, protoErr=1, all other outputs 0.
